// File: rtl/line_fifo_param.sv
// Line-granular single-clock FIFO: the writer fills whole lines, the reader only sees
// committed lines, streamed one word per clock through a registered output stage.
module line_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int LINE_SIZE = 1440,
  parameter int NUM_LINES = 5
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             wr_valid,
  input  logic [DATA_W-1:0]                wr_data,
  output logic                             wr_ready,
  input  logic                             wr_abort,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_sol,
  output logic                             rd_eol,
  output logic [$clog2(NUM_LINES+1)-1:0]   lines_used,
  output logic                             overflow,
  input  logic                             clear_err
);

  localparam int PX_W  = $clog2(LINE_SIZE);
  localparam int LN_W  = $clog2(NUM_LINES);
  localparam int CNT_W = $clog2(NUM_LINES + 1);

  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(LINE_SIZE - 1);
  localparam logic [LN_W-1:0]  LN_LAST  = LN_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES);

  logic [DATA_W-1:0] mem [NUM_LINES][LINE_SIZE];

  logic [LN_W-1:0]   wr_line_q, wr_line_d;
  logic [PX_W-1:0]   wr_px_q, wr_px_d;
  logic [LN_W-1:0]   rd_line_q, rd_line_d;
  logic [PX_W-1:0]   rd_px_q, rd_px_d;
  logic [CNT_W-1:0]  lines_used_q, lines_used_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_sol_q, rd_sol_d;
  logic              rd_eol_q, rd_eol_d;
  logic              overflow_q, overflow_d;

  logic wr_acc;
  logic wr_we;
  logic commit;
  logic load;
  logic free;

  assign wr_ready = (lines_used_q < CNT_FULL);
  assign wr_acc   = wr_valid && wr_ready && !wr_abort;
  assign wr_we    = wr_acc && !flush;
  assign commit   = wr_acc && (wr_px_q == PX_LAST);
  // The output stage refills whenever it is empty or being drained this cycle.
  assign load     = (!rd_valid_q || rd_ready) && (lines_used_q != '0);
  assign free     = load && (rd_px_q == PX_LAST);

  always_comb begin
    wr_line_d    = wr_line_q;
    wr_px_d      = wr_px_q;
    rd_line_d    = rd_line_q;
    rd_px_d      = rd_px_q;
    lines_used_d = lines_used_q;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_sol_d     = rd_sol_q;
    rd_eol_d     = rd_eol_q;
    overflow_d   = overflow_q;

    if (wr_valid && !wr_ready) begin
      overflow_d = 1'b1;
    end else if (clear_err) begin
      overflow_d = 1'b0;
    end

    if (flush) begin
      wr_line_d    = '0;
      wr_px_d      = '0;
      rd_line_d    = '0;
      rd_px_d      = '0;
      lines_used_d = '0;
      rd_valid_d   = 1'b0;
      rd_data_d    = '0;
      rd_sol_d     = 1'b0;
      rd_eol_d     = 1'b0;
    end else begin
      if (wr_abort) begin
        wr_px_d = '0;
      end else if (wr_acc) begin
        if (wr_px_q == PX_LAST) begin
          wr_px_d   = '0;
          wr_line_d = (wr_line_q == LN_LAST) ? '0 : wr_line_q + LN_W'(1);
        end else begin
          wr_px_d = wr_px_q + PX_W'(1);
        end
      end

      if (load) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem[rd_line_q][rd_px_q];
        rd_sol_d   = (rd_px_q == '0);
        rd_eol_d   = (rd_px_q == PX_LAST);
        if (rd_px_q == PX_LAST) begin
          rd_px_d   = '0;
          rd_line_d = (rd_line_q == LN_LAST) ? '0 : rd_line_q + LN_W'(1);
        end else begin
          rd_px_d = rd_px_q + PX_W'(1);
        end
      end else if (rd_ready && rd_valid_q) begin
        rd_valid_d = 1'b0;
      end

      if (commit && !free) begin
        lines_used_d = lines_used_q + CNT_W'(1);
      end else if (free && !commit) begin
        lines_used_d = lines_used_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_line_q    <= '0;
      wr_px_q      <= '0;
      rd_line_q    <= '0;
      rd_px_q      <= '0;
      lines_used_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_sol_q     <= 1'b0;
      rd_eol_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_line_q    <= wr_line_d;
      wr_px_q      <= wr_px_d;
      rd_line_q    <= rd_line_d;
      rd_px_q      <= rd_px_d;
      lines_used_q <= lines_used_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_sol_q     <= rd_sol_d;
      rd_eol_q     <= rd_eol_d;
      overflow_q   <= overflow_d;
    end
  end

  // Line storage is deliberately left unreset so it can map onto RAM.
  always_ff @(posedge clock) begin
    if (wr_we) begin
      mem[wr_line_q][wr_px_q] <= wr_data;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_sol     = rd_sol_q;
  assign rd_eol     = rd_eol_q;
  assign lines_used = lines_used_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_line_fifo_param.sv
// Bench for line_fifo_param: two instances (4x2 and 4x3 lines) share one stimulus stream
// and are compared every clock against a word-stream reference model.
module tb_line_fifo_param;

  localparam int LS = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush, wr_valid, wr_abort, rd_ready, clear_err;
  logic [7:0] wr_data;

  logic       wr_ready   [2];
  logic       rd_valid   [2];
  logic [7:0] rd_data    [2];
  logic       rd_sol     [2];
  logic       rd_eol     [2];
  logic [1:0] lines_used [2];
  logic       overflow   [2];

  int errors = 0;
  int checks = 0;

  // Reference model: committed words form one stream; head/tail are absolute word counts.
  int cw   [2][256];
  int pw   [2][LS];
  int head [2];
  int tail [2];
  int pn   [2];
  bit mov  [2];
  int mdat [2];
  bit msol [2];
  bit meol [2];
  bit movf [2];

  always #5 clock = ~clock;

  line_fifo_param #(.DATA_W(8), .LINE_SIZE(LS), .NUM_LINES(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[0]), .wr_abort(wr_abort),
    .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_data(rd_data[0]),
    .rd_sol(rd_sol[0]), .rd_eol(rd_eol[0]), .lines_used(lines_used[0]),
    .overflow(overflow[0]), .clear_err(clear_err)
  );

  line_fifo_param #(.DATA_W(8), .LINE_SIZE(LS), .NUM_LINES(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[1]), .wr_abort(wr_abort),
    .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_data(rd_data[1]),
    .rd_sol(rd_sol[1]), .rd_eol(rd_eol[1]), .lines_used(lines_used[1]),
    .overflow(overflow[1]), .clear_err(clear_err)
  );

  function automatic int nl(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int m_used(input int i);
    return tail[i] / LS - head[i] / LS;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d: observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_clear(input int i, input bit with_ovf);
    head[i] = 0; tail[i] = 0; pn[i] = 0;
    mov[i] = 0; mdat[i] = 0; msol[i] = 0; meol[i] = 0;
    if (with_ovf) movf[i] = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int used;
      bit full;
      bit load;
      if (!reset_n) begin
        model_clear(i, 1'b1);
      end else begin
        used = m_used(i);
        full = (used == nl(i));
        if (wr_valid && full) movf[i] = 1;
        else if (clear_err) movf[i] = 0;
        if (flush) begin
          model_clear(i, 1'b0);
        end else begin
          load = (!mov[i] || rd_ready) && (used > 0);
          if (load) begin
            mdat[i] = cw[i][head[i] % 256];
            msol[i] = (head[i] % LS == 0);
            meol[i] = (head[i] % LS == LS - 1);
            head[i]++;
            mov[i] = 1;
          end else if (rd_ready && mov[i]) begin
            mov[i] = 0;
          end
          if (wr_abort) begin
            pn[i] = 0;
          end else if (wr_valid && !full) begin
            pw[i][pn[i]] = int'(wr_data);
            pn[i]++;
            if (pn[i] == LS) begin
              for (int k = 0; k < LS; k++) cw[i][(tail[i] + k) % 256] = pw[i][k];
              tail[i] += LS;
              pn[i] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("rd_valid",   i, 32'(rd_valid[i]),   32'(mov[i]));
      chk("rd_data",    i, 32'(rd_data[i]),    32'(mdat[i]));
      chk("rd_sol",     i, 32'(rd_sol[i]),     32'(msol[i]));
      chk("rd_eol",     i, 32'(rd_eol[i]),     32'(meol[i]));
      chk("lines_used", i, 32'(lines_used[i]), 32'(m_used(i)));
      chk("wr_ready",   i, 32'(wr_ready[i]),   32'(m_used(i) < nl(i)));
      chk("overflow",   i, 32'(overflow[i]),   32'(movf[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    flush = 0; wr_valid = 0; wr_abort = 0; clear_err = 0; wr_data = 8'h00;
  endtask

  initial begin
    idle_inputs();
    rd_ready = 0;
    reset_n  = 0;
    for (int i = 0; i < 2; i++) begin
      model_clear(i, 1'b1);
      for (int k = 0; k < 256; k++) cw[i][k] = 0;
    end
    #3;
    check_all();
    cyc();
    reset_n = 1;
    cyc();

    // Single line, reader always ready
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1; wr_data = 8'(11 + k);
      cyc();
    end
    wr_valid = 0;
    chk("t2_used_after_commit", 0, 32'(lines_used[0]), 32'd1);
    cyc();
    chk("t2_first_word", 0, 32'(rd_data[0]), 32'd11);
    chk("t2_first_sol",  0, 32'(rd_sol[0]),  32'd1);
    repeat (3) cyc();
    chk("t2_last_word", 0, 32'(rd_data[0]), 32'd14);
    chk("t2_last_eol",  0, 32'(rd_eol[0]),  32'd1);
    repeat (3) cyc();

    // Fill to full with reader stalled, then drain
    rd_ready = 0;
    for (int k = 1; k <= 12; k++) begin
      wr_valid = 1; wr_data = 8'(k);
      cyc();
      if (k == 8) chk("t3_full_wr_ready", 0, 32'(wr_ready[0]), 32'd0);
      if (k == 9) chk("t3_overflow_set", 0, 32'(overflow[0]), 32'd1);
    end
    wr_valid = 0;
    rd_ready = 1;
    repeat (14) cyc();
    clear_err = 1;
    cyc();
    clear_err = 0;
    chk("t3_overflow_clr", 0, 32'(overflow[0]), 32'd0);

    // Partial line aborted, including a beat dropped by a same-cycle abort
    wr_valid = 1; wr_data = 8'hA1; cyc();
    wr_data = 8'hA2; cyc();
    wr_abort = 1; wr_data = 8'hEE; cyc();
    wr_abort = 0;
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'(8'hB1 + k);
      cyc();
      chk("t4_used_max1", 0, 32'(lines_used[0] <= 2'd1), 32'd1);
    end
    wr_valid = 0;
    cyc();
    chk("t4_first_b1", 0, 32'(rd_data[0]), 32'hB1);
    repeat (5) cyc();

    // Flush with lines buffered and a word held in the output stage
    rd_ready = 0;
    for (int k = 0; k < 9; k++) begin
      wr_valid = 1; wr_data = 8'(8'h60 + k);
      cyc();
    end
    wr_valid = 0;
    flush = 1;
    cyc();
    flush = 0;
    chk("t6_rd_valid", 0, 32'(rd_valid[0]),   32'd0);
    chk("t6_used",     0, 32'(lines_used[0]), 32'd0);
    chk("t6_ovf_kept", 0, 32'(overflow[0]),   32'd1);
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1; wr_data = 8'(8'h70 + k);
      cyc();
    end
    wr_valid = 0;
    repeat (6) cyc();
    clear_err = 1; cyc(); clear_err = 0;

    // Seven back-to-back lines, first with reader always ready, then with 50% ready
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 7 * LS; k++) begin
        wr_valid = 1; wr_data = 8'($urandom);
        rd_ready = (pass == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        cyc();
        while (!wr_ready[1] && pass == 1) begin
          rd_ready = 1'($urandom_range(0, 1));
          cyc();
        end
      end
      wr_valid = 0;
      rd_ready = 1;
      repeat (3 * LS + 4) cyc();
    end

    // Random mix of gaps, aborts, flushes, error clears and back-pressure
    for (int n = 0; n < 400; n++) begin
      wr_valid  = ($urandom_range(0, 9) < 7);
      wr_data   = 8'($urandom);
      wr_abort  = ($urandom_range(0, 31) == 0);
      clear_err = ($urandom_range(0, 15) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      rd_ready  = 1'($urandom_range(0, 1));
      cyc();
    end
    idle_inputs();

    // Asynchronous reset in the middle of a line with data buffered
    rd_ready = 0;
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1; wr_data = 8'(8'h90 + k);
      cyc();
    end
    #2;
    reset_n = 0;
    #1;
    chk("t1_rd_valid", 0, 32'(rd_valid[0]),   32'd0);
    chk("t1_wr_ready", 0, 32'(wr_ready[0]),   32'd1);
    chk("t1_used",     0, 32'(lines_used[0]), 32'd0);
    chk("t1_overflow", 0, 32'(overflow[0]),   32'd0);
    for (int i = 0; i < 2; i++) model_clear(i, 1'b1);
    wr_valid = 0;
    cyc();
    reset_n = 1;
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1; wr_data = 8'(8'hC0 + k);
      cyc();
    end
    wr_valid = 0;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
